// File: rtl/regfile_pkg.sv
// Shared sizing, entry types and arbitration source encoding for the writeback unit.
package regfile_pkg;
  localparam int unsigned DEPTH      = 32;
  localparam int unsigned BITS       = 64;
  localparam int unsigned QDEPTH     = 4;
  localparam int unsigned STARVE_MAX = 3;

  localparam int unsigned IDXW    = $clog2(DEPTH);
  localparam int unsigned QPTRW   = $clog2(QDEPTH);
  localparam int unsigned STARVEW = $clog2(STARVE_MAX + 1);

  typedef logic [IDXW-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t        rd;
    logic [BITS-1:0] data;
  } wb_entry_t;

  localparam reg_idx_t REG_ZERO = '0;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_FIFO = 2'd2
  } wb_src_t;
endpackage

// File: rtl/regfile_writeback_unit_if.sv
// Writeback-side bus: ALU/load results in, scoreboard and register-file write port out.
// Optional forwarding outputs appear when WB_BYPASS_EN is defined.
interface regfile_writeback_unit_if;
  import regfile_pkg::*;

  logic             alu_valid;
  reg_idx_t         alu_rd;
  logic [BITS-1:0]  alu_data;
  logic             alu_stall;
  logic             mem_valid;
  reg_idx_t         mem_rd;
  logic [BITS-1:0]  mem_data;
  logic             mem_ready;
  logic             issue_en;
  reg_idx_t         issue_rd;
  logic [DEPTH-1:0] busy;
  reg_idx_t         addressw;
  logic [BITS-1:0]  writeData;
  logic             writeEn;
`ifdef WB_BYPASS_EN
  logic             fwd_valid;
  reg_idx_t         fwd_rd;
  logic [BITS-1:0]  fwd_data;
`endif

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, issue_en, issue_rd,
`ifdef WB_BYPASS_EN
    output fwd_valid, fwd_rd, fwd_data,
`endif
    output alu_stall, mem_ready, busy, addressw, writeData, writeEn
  );

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, issue_en, issue_rd,
`ifdef WB_BYPASS_EN
    input  fwd_valid, fwd_rd, fwd_data,
`endif
    input  alu_stall, mem_ready, busy, addressw, writeData, writeEn
  );
endinterface

// File: rtl/wb_fifo.sv
// Circular buffer of pending load results; pointers carry one wrap bit to tell full from empty.
module wb_fifo
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  wb_entry_t i_entry,
  input  logic      i_pop,
  output wb_entry_t o_head_c,
  output logic      o_full_c,
  output logic      o_empty_c
);
  localparam int unsigned PW = QPTRW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  wb_entry_t     r_mem [QDEPTH];

  assign o_empty_c = (r_wr_ptr == r_rd_ptr);
  assign o_full_c  = (r_wr_ptr[QPTRW] != r_rd_ptr[QPTRW]) &&
                     (r_wr_ptr[QPTRW-1:0] == r_rd_ptr[QPTRW-1:0]);
  assign o_head_c  = r_mem[r_rd_ptr[QPTRW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[QPTRW-1:0]] <= i_entry;
  end
endmodule

// File: rtl/regfile_writeback_unit.sv
// Merges ALU and buffered load results onto the single register-file write port and
// tracks per-register pending writes. Optional forwarding outputs: WB_BYPASS_EN.
module regfile_writeback_unit
  import regfile_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  regfile_writeback_unit_if.slave  wb
);
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_push;
  logic               w_pop;
  wb_entry_t          w_head;
  wb_entry_t          w_push_entry;
  wb_entry_t          w_sel;
  wb_src_t            w_src;
  logic [STARVEW-1:0] w_starve_nxt;
  logic [DEPTH-1:0]   w_busy_nxt;

  logic               r_write_en;
  reg_idx_t           r_addressw;
  logic [BITS-1:0]    r_write_data;
  logic [DEPTH-1:0]   r_busy;
  logic [STARVEW-1:0] r_starve;
  logic               r_alu_stall;

  assign w_push            = wb.mem_valid && !w_fifo_full;
  assign w_push_entry.rd   = wb.mem_rd;
  assign w_push_entry.data = wb.mem_data;

  wb_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_entry   (w_push_entry),
    .i_pop     (w_pop),
    .o_head_c  (w_head),
    .o_full_c  (w_fifo_full),
    .o_empty_c (w_fifo_empty)
  );

  // Write-port arbitration: forced pop, then ALU, then FIFO drain.
  always_comb begin
    w_src        = SRC_NONE;
    w_pop        = 1'b0;
    w_sel        = '0;
    w_starve_nxt = r_starve;
    if (r_alu_stall && !w_fifo_empty)      w_src = SRC_FIFO;
    else if (wb.alu_valid && !r_alu_stall) w_src = SRC_ALU;
    else if (!w_fifo_empty)                w_src = SRC_FIFO;
    case (w_src)
      SRC_ALU: begin
        w_sel.rd   = wb.alu_rd;
        w_sel.data = wb.alu_data;
      end
      SRC_FIFO: begin
        w_pop = 1'b1;
        w_sel = w_head;
      end
      default: ;
    endcase
    if (w_fifo_empty || w_pop)  w_starve_nxt = '0;
    else if (w_src == SRC_ALU)  w_starve_nxt = r_starve + STARVEW'(1);
  end

  // Scoreboard: clear on the commit edge, then a same-edge issue re-sets the bit.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_write_en) w_busy_nxt[r_addressw] = 1'b0;
    if (wb.issue_en && (wb.issue_rd != REG_ZERO)) w_busy_nxt[wb.issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_write_en   <= 1'b0;
      r_addressw   <= REG_ZERO;
      r_write_data <= '0;
      r_busy       <= '0;
      r_starve     <= '0;
      r_alu_stall  <= 1'b0;
    end else begin
      r_write_en <= (w_src != SRC_NONE) && (w_sel.rd != REG_ZERO);
      if (w_src != SRC_NONE) begin
        r_addressw   <= w_sel.rd;
        r_write_data <= w_sel.data;
      end
      r_busy      <= w_busy_nxt;
      r_starve    <= w_starve_nxt;
      r_alu_stall <= (w_starve_nxt == STARVEW'(STARVE_MAX));
    end
  end

  assign wb.writeEn   = r_write_en;
  assign wb.addressw  = r_addressw;
  assign wb.writeData = r_write_data;
  assign wb.busy      = r_busy;
  assign wb.alu_stall = r_alu_stall;
  assign wb.mem_ready = !w_fifo_full;

`ifdef WB_BYPASS_EN
  assign wb.fwd_valid = r_write_en;
  assign wb.fwd_rd    = r_addressw;
  assign wb.fwd_data  = r_write_data;
`endif
endmodule
